// File: rtl/duck_pixel_fetch.sv
// duck_pixel_fetch
//   Takes per-pixel sprite read requests and issues reads to the 4-bit index
//   sprite memory. Responses come back in order and are matched to their
//   requests. Each index is mapped through a writable palette. Pixels go to
//   the VGA color mapper in request order over a valid/ready handshake.
//   Transparent indices and pixels outside the sprite box resolve to
//   BG_COLOR.
//
// Ports
//   Clk, Reset              system clock; synchronous active-high reset
//   in_valid/in_ready       request handshake
//   in_addr, in_is_duck     sprite address and in-sprite flag
//   mem_rd_en/mem_rd_addr   memory read strobe and address (combinational)
//   mem_rd_valid/_data      in-order memory response, no backpressure
//   pal_we/_waddr/_wdata    palette write port
//   out_valid/out_ready     pixel handshake
//   out_color, out_opaque   composited color; 1 = sprite pixel drawn
//   err_unexpected          sticky: response with no pending duck read
module duck_pixel_fetch #(
  parameter int                  ADDR_W          = 19,
  parameter int                  IDX_W           = 4,
  parameter int                  COLOR_W         = 24,
  parameter int                  DEPTH           = 4,
  parameter int                  TRANSPARENT_IDX = 0,
  parameter logic [COLOR_W-1:0]  BG_COLOR        = 24'h3FBFFF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic               in_is_duck,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_valid,
  input  logic [IDX_W-1:0]   mem_rd_data,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_waddr,
  input  logic [COLOR_W-1:0] pal_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_opaque,
  output logic               err_unexpected
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PAL_N = 1 << IDX_W;

  logic [DEPTH-1:0]   slot_duck;
  logic [DEPTH-1:0]   slot_have;
  logic [IDX_W-1:0]   slot_idx [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [COLOR_W-1:0] palette [PAL_N];

  logic               push;
  logic               pop;
  logic               fill_found;
  logic [PTR_W-1:0]   fill_ptr;
  logic [PTR_W-1:0]   cand;
  logic [IDX_W-1:0]   head_idx;

  assign in_ready    = (count < CNT_W'(DEPTH));
  assign push        = in_valid && in_ready;
  assign mem_rd_en   = push && in_is_duck;
  assign mem_rd_addr = in_addr;

  assign head_idx   = slot_idx[rd_ptr];
  assign out_valid  = (count != '0) && slot_have[rd_ptr];
  assign pop        = out_valid && out_ready;
  assign out_opaque = slot_duck[rd_ptr] && (head_idx != IDX_W'(TRANSPARENT_IDX));
  assign out_color  = out_opaque ? palette[head_idx] : BG_COLOR;

  // Fill pointer: the oldest occupied duck slot still waiting for its index.
  // Non-duck slots are skipped. A slot pushed this cycle is never a candidate,
  // because memory latency is at least one cycle.
  always_comb begin
    fill_found = 1'b0;
    fill_ptr   = rd_ptr;
    cand       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand = rd_ptr + PTR_W'(i);
      if (!fill_found && (CNT_W'(i) < count) && slot_duck[cand] && !slot_have[cand]) begin
        fill_found = 1'b1;
        fill_ptr   = cand;
      end
    end
  end

  // The push, pop and fill targets never alias. Push only writes a free slot.
  // Pop needs have_data, so the head cannot be the fill target.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot_duck      <= '0;
      slot_have      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_unexpected <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_idx[i] <= '0;
    end else begin
      if (push) begin
        slot_duck[wr_ptr] <= in_is_duck;
        slot_have[wr_ptr] <= !in_is_duck;
        slot_idx[wr_ptr]  <= '0;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        slot_duck[rd_ptr] <= 1'b0;
        slot_have[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (mem_rd_valid) begin
        if (fill_found) begin
          slot_idx[fill_ptr]  <= mem_rd_data;
          slot_have[fill_ptr] <= 1'b1;
        end else begin
          err_unexpected <= 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Reads are combinational, so a write becomes visible on the next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PAL_N; i++) palette[i] <= '0;
    end else if (pal_we) begin
      palette[pal_waddr] <= pal_wdata;
    end
  end

endmodule
